// File: rtl/bus_pkg.sv
// Shared bus definitions for the split-capable initiator/target pair.
//   state_t    : initiator FSM states
//   RW_WRITE/RW_READ : encoding of the bus rw bit
//   BUS_ADDR_W/BUS_DATA_W : default bus widths shared with the target
package bus_pkg;

  localparam int unsigned BUS_ADDR_W = 16;
  localparam int unsigned BUS_DATA_W = 8;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_ADDR,
    ST_WAIT_RESP,
    ST_SPLIT_WAIT,
    ST_RESP
  } state_t;

  // States in which the initiator is waiting on the target and the
  // timeout counter runs.
  function automatic logic is_wait_state(state_t s);
    return (s == ST_WAIT_RESP) || (s == ST_SPLIT_WAIT);
  endfunction

endpackage

// File: rtl/bus_timeout_counter.sv
// Saturating cycle counter used to bound how long the initiator waits on
// the target.
//   clk, rst   : clock, synchronous active-high reset
//   clear_i    : restart the count from zero (wins over en_i)
//   en_i       : count this cycle
//   expired_o  : count has reached LIMIT-1 (never asserted when LIMIT == 0)
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CW = (LIMIT > 0) ? $clog2(LIMIT + 1) : 1;
  localparam logic [CW-1:0] SAT  = CW'(LIMIT);
  localparam logic [CW-1:0] LAST = (LIMIT > 0) ? CW'(LIMIT - 1) : '0;

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != SAT)) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (LIMIT > 0) && (count_q == LAST);

endmodule

// File: rtl/split_initiator.sv
// Bus initiator issuing single-beat read/write transactions to a
// split-capable target, one transaction in flight at a time.
//   Local command side : cmd_valid/cmd_rw/cmd_addr/cmd_wdata in, cmd_ready out
//   Local response side: rsp_valid pulse with rsp_rdata and rsp_err, busy
//   Arbiter side       : bus_req out, bus_grant in
//   Target side        : bus_addr(_valid), bus_wdata(_valid), bus_rw out;
//                        target_ready, target_ack, target_split_ack,
//                        target_rdata(_valid) in
// Every output is a flop loaded from the next-state decode, so outputs line
// up with the state register without any combinational path to the ports.
module split_initiator
  import bus_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = BUS_ADDR_W,
  parameter int unsigned DATA_WIDTH     = BUS_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic                  cmd_rw,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  cmd_ready,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  bus_req,
  input  logic                  bus_grant,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic                  bus_addr_valid,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic                  bus_wdata_valid,
  output logic                  bus_rw,
  input  logic                  target_ready,
  input  logic                  target_ack,
  input  logic                  target_split_ack,
  input  logic [DATA_WIDTH-1:0] target_rdata,
  input  logic                  target_rdata_valid
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rw_q, rw_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

  logic                  cmd_ready_q, rsp_valid_q, rsp_err_q, busy_q, bus_req_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, bus_wdata_q;
  logic [ADDR_WIDTH-1:0] bus_addr_q;
  logic                  bus_addr_valid_q, bus_wdata_valid_q, bus_rw_q;

  logic cap_rdata, tmo_hit, tmo_expired, tmo_clear, tmo_en;

  // The counter restarts when the address phase hands over to WAIT_RESP and
  // again when a split moves the wait into SPLIT_WAIT.
  assign tmo_clear = (state_q == ST_ADDR) ||
                     ((state_q == ST_WAIT_RESP) && (state_d == ST_SPLIT_WAIT));
  assign tmo_en    = is_wait_state(state_q);

  bus_timeout_counter #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmo_clear),
    .en_i      (tmo_en),
    .expired_o (tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rw_d      = rw_q;
    wdata_d   = wdata_q;
    cap_rdata = 1'b0;
    tmo_hit   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d  = cmd_addr;
          rw_d    = cmd_rw;
          wdata_d = cmd_wdata;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (bus_grant && target_ready) state_d = ST_ADDR;
      end
      ST_ADDR: state_d = ST_WAIT_RESP;
      ST_WAIT_RESP: begin
        // An ack always takes precedence over a simultaneous split_ack; a
        // read ack without data is not a completion and keeps waiting.
        if (target_ack && (rw_q == RW_WRITE)) begin
          state_d = ST_RESP;
        end else if (target_ack && target_rdata_valid) begin
          state_d   = ST_RESP;
          cap_rdata = 1'b1;
        end else if (!target_ack && target_split_ack && (rw_q == RW_READ)) begin
          state_d = ST_SPLIT_WAIT;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          tmo_hit = 1'b1;
        end
      end
      ST_SPLIT_WAIT: begin
        // bus_grant is deliberately not looked at here: the target drives
        // the deferred data once the arbiter hands it the bus.
        if (target_ack && target_rdata_valid) begin
          state_d   = ST_RESP;
          cap_rdata = 1'b1;
        end else if (tmo_expired) begin
          state_d = ST_RESP;
          tmo_hit = 1'b1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      addr_q            <= '0;
      rw_q              <= 1'b0;
      wdata_q           <= '0;
      cmd_ready_q       <= 1'b0;
      rsp_valid_q       <= 1'b0;
      rsp_err_q         <= 1'b0;
      rsp_rdata_q       <= '0;
      busy_q            <= 1'b0;
      bus_req_q         <= 1'b0;
      bus_addr_q        <= '0;
      bus_addr_valid_q  <= 1'b0;
      bus_wdata_q       <= '0;
      bus_wdata_valid_q <= 1'b0;
      bus_rw_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      addr_q            <= addr_d;
      rw_q              <= rw_d;
      wdata_q           <= wdata_d;
      cmd_ready_q       <= (state_d == ST_IDLE);
      busy_q            <= (state_d != ST_IDLE);
      bus_req_q         <= (state_d == ST_REQ) || (state_d == ST_ADDR) ||
                           (state_d == ST_WAIT_RESP);
      bus_addr_valid_q  <= (state_d == ST_ADDR);
      bus_addr_q        <= (state_d == ST_ADDR) ? addr_q : '0;
      bus_rw_q          <= (state_d == ST_ADDR) && rw_q;
      bus_wdata_valid_q <= (state_d == ST_ADDR) && (rw_q == RW_WRITE);
      bus_wdata_q       <= ((state_d == ST_ADDR) && (rw_q == RW_WRITE)) ? wdata_q : '0;
      rsp_valid_q       <= (state_d == ST_RESP);
      rsp_err_q         <= tmo_hit;
      // Timeouts and writes report zero read data.
      rsp_rdata_q       <= cap_rdata ? target_rdata : '0;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_err         = rsp_err_q;
  assign rsp_rdata       = rsp_rdata_q;
  assign busy            = busy_q;
  assign bus_req         = bus_req_q;
  assign bus_addr        = bus_addr_q;
  assign bus_addr_valid  = bus_addr_valid_q;
  assign bus_wdata       = bus_wdata_q;
  assign bus_wdata_valid = bus_wdata_valid_q;
  assign bus_rw          = bus_rw_q;

endmodule

// File: tb/tb_split_initiator.sv
// Directed bench for split_initiator; the bench plays arbiter and target.
module tb_split_initiator;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_rw, cmd_ready;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_wdata;
  logic        rsp_valid, rsp_err, busy, bus_req, bus_grant;
  logic [7:0]  rsp_rdata, bus_wdata, target_rdata;
  logic [15:0] bus_addr;
  logic        bus_addr_valid, bus_wdata_valid, bus_rw;
  logic        target_ready, target_ack, target_split_ack, target_rdata_valid;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [7:0] mem [256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  split_initiator #(
    .ADDR_WIDTH     (16),
    .DATA_WIDTH     (8),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .cmd_valid          (cmd_valid),
    .cmd_rw             (cmd_rw),
    .cmd_addr           (cmd_addr),
    .cmd_wdata          (cmd_wdata),
    .cmd_ready          (cmd_ready),
    .rsp_valid          (rsp_valid),
    .rsp_rdata          (rsp_rdata),
    .rsp_err            (rsp_err),
    .busy               (busy),
    .bus_req            (bus_req),
    .bus_grant          (bus_grant),
    .bus_addr           (bus_addr),
    .bus_addr_valid     (bus_addr_valid),
    .bus_wdata          (bus_wdata),
    .bus_wdata_valid    (bus_wdata_valid),
    .bus_rw             (bus_rw),
    .target_ready       (target_ready),
    .target_ack         (target_ack),
    .target_split_ack   (target_split_ack),
    .target_rdata       (target_rdata),
    .target_rdata_valid (target_rdata_valid)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_cmd(input logic rw, input logic [15:0] a, input logic [7:0] wd);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_wdata = wd;
  endtask

  // Full transaction with immediate grant. Writes are acked in the first
  // WAIT_RESP cycle; reads answer from mem, optionally through a split.
  // poke keeps cmd_valid asserted while the block is busy.
  task automatic txn(input logic rw, input logic [15:0] a, input logic [7:0] wd,
                     input bit split, input bit poke,
                     output logic [7:0] rd, output logic er, output int cycles);
    int k;
    int c0;
    logic [15:0] pa;
    drive_cmd(rw, a, wd);
    bus_grant    = 1'b1;
    target_ready = 1'b1;
    c0 = cyc;
    tick;
    cmd_valid = poke;
    if (poke) begin
      cmd_rw    = 1'b1;
      cmd_wdata = 8'h00;
    end
    k = 0;
    while (!bus_addr_valid && k < 20) begin
      tick;
      k++;
    end
    cmd_valid = 1'b0;
    bus_grant = 1'b0;
    pa = bus_addr;
    if (bus_wdata_valid) mem[pa[7:0]] = bus_wdata;
    tick;
    if (rw) begin
      target_ack = 1'b1;
    end else begin
      if (split) begin
        target_split_ack = 1'b1;
        tick;
        target_split_ack = 1'b0;
        tick;
        tick;
      end
      target_ack         = 1'b1;
      target_rdata_valid = 1'b1;
      target_rdata       = mem[pa[7:0]];
    end
    tick;
    target_ack         = 1'b0;
    target_rdata_valid = 1'b0;
    target_rdata       = 8'h00;
    k = 0;
    while (!rsp_valid && k < 20) begin
      tick;
      k++;
    end
    rd     = rsp_rdata;
    er     = rsp_err;
    cycles = rsp_valid ? (cyc - c0 + 1) : -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd;
    logic       er;
    int         cyc_n;
    int         n;
    int         bad;

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    bus_grant = 1'b0; target_ready = 1'b0; target_ack = 1'b0;
    target_split_ack = 1'b0; target_rdata = '0; target_rdata_valid = 1'b0;
    tick;
    tick;
    check_eq("reset_outputs",
             {cmd_ready, rsp_valid, rsp_err, busy, bus_req, bus_addr_valid,
              bus_wdata_valid, bus_rw, rsp_rdata, bus_addr, bus_wdata}, 64'h0);
    rst = 1'b0;
    tick;
    check_eq("ready_after_reset", cmd_ready, 1'b1);

    // 1: write 0x0012 <- 0xA5, immediate grant, ack one cycle after ADDR
    drive_cmd(1'b1, 16'h0012, 8'hA5);
    bus_grant = 1'b1; target_ready = 1'b1;
    tick;
    cmd_valid = 1'b0;
    check_eq("t1_req", {cmd_ready, busy, bus_req}, 3'b011);
    tick;
    check_eq("t1_addr_phase", {bus_addr_valid, bus_rw, bus_wdata_valid}, 3'b111);
    check_eq("t1_addr", bus_addr, 16'h0012);
    check_eq("t1_wdata", bus_wdata, 8'hA5);
    bus_grant = 1'b0;
    tick;
    check_eq("t1_wait", {bus_addr_valid, bus_wdata_valid, bus_req}, 3'b001);
    target_ack = 1'b1;
    tick;
    target_ack = 1'b0;
    check_eq("t1_rsp", {rsp_valid, rsp_err, bus_req}, 3'b100);
    tick;
    check_eq("t1_idle", {rsp_valid, cmd_ready, busy}, 3'b010);

    // 2: read 0x0012 through a split, grant during SPLIT_WAIT ignored
    drive_cmd(1'b0, 16'h0012, 8'h00);
    bus_grant = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    check_eq("t2_addr_phase", {bus_addr_valid, bus_rw, bus_wdata_valid}, 3'b100);
    bus_grant = 1'b0;
    tick;
    target_split_ack = 1'b1;
    tick;
    target_split_ack = 1'b0;
    check_eq("t2_split_drop_req", {bus_req, busy, rsp_valid}, 3'b010);
    bus_grant = 1'b1;
    tick;
    tick;
    check_eq("t2_grant_ignored", {bus_req, bus_addr_valid, rsp_valid}, 3'b000);
    bus_grant = 1'b0;
    target_rdata = 8'hA5; target_rdata_valid = 1'b1; target_ack = 1'b1;
    tick;
    target_rdata = 8'h00; target_rdata_valid = 1'b0; target_ack = 1'b0;
    check_eq("t2_rsp", {rsp_valid, rsp_err}, 2'b10);
    check_eq("t2_rdata", rsp_rdata, 8'hA5);
    tick;

    // 3: grant held low 10 cycles in REQ
    drive_cmd(1'b1, 16'h0034, 8'h77);
    tick;
    cmd_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (!bus_req || bus_addr_valid) bad++;
    end
    check_eq("t3_stall", bad, 0);
    bus_grant = 1'b1;
    tick;
    bus_grant = 1'b0;
    check_eq("t3_addr_after_grant", {bus_addr_valid, bus_addr}, {1'b1, 16'h0034});
    tick;
    target_ack = 1'b1;
    tick;
    target_ack = 1'b0;
    check_eq("t3_rsp", {rsp_valid, rsp_err}, 2'b10);
    tick;

    // 4: read never acked -> timeout after TMO cycles in WAIT_RESP
    drive_cmd(1'b0, 16'h0040, 8'h00);
    bus_grant = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    bus_grant = 1'b0;
    check_eq("t4_addr_phase", bus_addr_valid, 1'b1);
    n = 0;
    do begin
      tick;
      n++;
    end while (!rsp_valid && n < 20);
    check_eq("t4_timeout_delay", n, TMO + 1);
    check_eq("t4_rsp", {rsp_valid, rsp_err, rsp_rdata}, {2'b11, 8'h00});
    tick;
    check_eq("t4_idle", {cmd_ready, busy}, 2'b10);

    // late ack / data while idle must not produce a response
    target_ack = 1'b1; target_rdata_valid = 1'b1; target_rdata = 8'h99;
    tick;
    tick;
    target_ack = 1'b0; target_rdata_valid = 1'b0; target_rdata = 8'h00;
    check_eq("late_ack_ignored", {rsp_valid, busy, cmd_ready}, 3'b001);

    // 5: reset during SPLIT_WAIT
    drive_cmd(1'b0, 16'h0012, 8'h00);
    bus_grant = 1'b1;
    tick;
    cmd_valid = 1'b0;
    tick;
    bus_grant = 1'b0;
    tick;
    target_split_ack = 1'b1;
    tick;
    target_split_ack = 1'b0;
    check_eq("t5_in_split", {busy, bus_req}, 2'b10);
    rst = 1'b1;
    target_ack = 1'b1; target_rdata_valid = 1'b1; target_rdata = 8'hA5;
    tick;
    check_eq("t5_reset_outputs",
             {cmd_ready, rsp_valid, rsp_err, busy, bus_req, bus_addr_valid,
              bus_wdata_valid, bus_rw, rsp_rdata, bus_addr, bus_wdata}, 64'h0);
    rst = 1'b0;
    target_ack = 1'b0; target_rdata_valid = 1'b0; target_rdata = 8'h00;
    tick;
    check_eq("t5_after_reset", {cmd_ready, rsp_valid, busy}, 3'b100);
    txn(1'b1, 16'h0001, 8'h3C, 1'b0, 1'b0, rd, er, cyc_n);
    check_eq("t5_write_latency", cyc_n, 5);
    check_eq("t5_write_err", er, 1'b0);
    check_eq("t5_wdata_seen", mem[1], 8'h3C);
    tick;

    // 6: back-to-back write then read, extra cmd_valid while busy ignored
    txn(1'b1, 16'h00FF, 8'h5A, 1'b0, 1'b0, rd, er, cyc_n);
    check_eq("t6_write_latency", cyc_n, 5);
    n = 0;
    do begin
      tick;
      n++;
    end while (!cmd_ready && n < 10);
    check_eq("t6_first_ready", n, 1);
    txn(1'b0, 16'h00FF, 8'h00, 1'b0, 1'b1, rd, er, cyc_n);
    check_eq("t6_read_data", rd, 8'h5A);
    check_eq("t6_read_err", er, 1'b0);
    check_eq("t6_read_latency", cyc_n, 5);
    tick;
    tick;
    check_eq("t6_no_queued_cmd", {busy, bus_req, rsp_valid, cmd_ready}, 4'b0001);
    check_eq("t6_mem_intact", mem[8'hFF], 8'h5A);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
